// File: rtl/adder_tree_pkg.sv
// Shared helpers for the adder tree accumulator: width derivations and the
// side-band record that travels alongside the tree data.
package adder_tree_pkg;

  typedef struct packed {
    logic vld;
    logic first;
    logic last;
  } sideband_t;

  function automatic int clog2_f(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) r++;
    return r;
  endfunction

  // Width of a lane after `level` pairwise additions (one growth bit per level).
  function automatic int lane_width(input int in_w, input int level);
    return in_w + level;
  endfunction

  function automatic int acc_width(input int in_w, input int lvl, input int ext);
    return in_w + lvl + ext;
  endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One registered level of the adder tree: PAIRS signed pairwise sums, each one
// bit wider than its operands so nothing is lost inside the tree.
module adder_tree_level #(
  parameter int PAIRS = 1,
  parameter int OP_W  = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [2*PAIRS*OP_W-1:0]   din,
  output logic [PAIRS*(OP_W+1)-1:0] dout
);

  for (genvar p = 0; p < PAIRS; p++) begin : g_pair
    logic signed [OP_W-1:0] a;
    logic signed [OP_W-1:0] b;
    logic signed [OP_W:0]   sum_q;

    assign a = din[2*p*OP_W +: OP_W];
    assign b = din[(2*p+1)*OP_W +: OP_W];

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        sum_q <= '0;
      end else begin
        sum_q <= (OP_W+1)'(a) + (OP_W+1)'(b);
      end
    end

    assign dout[p*(OP_W+1) +: OP_W+1] = sum_q;
  end

endmodule

// File: rtl/adder_tree_acc.sv
// Pipelined signed adder tree feeding a packet accumulator with optional
// saturation of the reported result.
module adder_tree_acc
  import adder_tree_pkg::*;
#(
  parameter int NUM_IN  = 8,
  parameter int IN_W    = 16,
  parameter int ACC_EXT = 8,
  parameter int OUT_W   = 24,
  parameter int SAT     = 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     vld_i,
  input  logic                     first_i,
  input  logic                     last_i,
  input  logic                     clr_i,
  input  logic [NUM_IN*IN_W-1:0]   data_i,
  output logic [OUT_W-1:0]         acc_o,
  output logic                     vld_o,
  output logic                     ovf_o
);

  localparam int LVL    = clog2_f(NUM_IN);
  localparam int TREE_W = lane_width(IN_W, LVL);
  localparam int ACC_W  = acc_width(IN_W, LVL, ACC_EXT);
  localparam int HI_W   = ACC_W - OUT_W + 1;

  logic [NUM_IN*IN_W-1:0] data_q;
  sideband_t              sb_q [LVL+1];

  logic signed [TREE_W-1:0] tree_sum;
  logic signed [ACC_W-1:0]  tree_ext;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_next;
  logic [HI_W-1:0]          acc_hi;
  logic                     clamp;
  logic [OUT_W-1:0]         fmt_val;

  // Input register stage; the side-band entry 0 lines up with it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_q <= '0;
    end else begin
      data_q <= data_i;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i <= LVL; i++) sb_q[i] <= '0;
    end else if (clr_i) begin
      for (int i = 0; i <= LVL; i++) sb_q[i].vld <= 1'b0;
    end else begin
      sb_q[0] <= {vld_i, vld_i & first_i, vld_i & last_i};
      for (int i = 1; i <= LVL; i++) sb_q[i] <= sb_q[i-1];
    end
  end

  for (genvar k = 0; k <= LVL; k++) begin : stg
    logic [(NUM_IN>>k)*(IN_W+k)-1:0] bus;
  end

  assign stg[0].bus = data_q;

  for (genvar k = 0; k < LVL; k++) begin : lvl
    adder_tree_level #(
      .PAIRS (NUM_IN >> (k+1)),
      .OP_W  (IN_W + k)
    ) u_level (
      .clk  (clk),
      .rstn (rstn),
      .din  (stg[k].bus),
      .dout (stg[k+1].bus)
    );
  end

  assign tree_sum = stg[LVL].bus;
  assign tree_ext = ACC_W'(tree_sum);

  always_comb begin
    acc_next = acc_q + tree_ext;
    if (sb_q[LVL].first) acc_next = tree_ext;
  end

  // The result fits OUT_W exactly when every bit from OUT_W-1 upward agrees.
  assign acc_hi = acc_next[ACC_W-1:OUT_W-1];
  assign clamp  = (SAT != 0) && !((&acc_hi) || !(|acc_hi));

  always_comb begin
    fmt_val = acc_next[OUT_W-1:0];
    if (clamp) begin
      fmt_val = acc_next[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                  : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q <= '0;
      acc_o <= '0;
      ovf_o <= 1'b0;
      vld_o <= 1'b0;
    end else begin
      vld_o <= 1'b0;
      if (clr_i) begin
        acc_q <= '0;
      end else if (sb_q[LVL].vld) begin
        acc_q <= acc_next;
        if (sb_q[LVL].last) begin
          acc_o <= fmt_val;
          ovf_o <= clamp;
          vld_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/adder_tree_acc.md
ADDER_TREE_ACC -- requirements
Module: adder_tree_acc

Interface
REQ-001 SHALL have parameter NUM_IN, default 8: number of signed input lanes; power of 2, range 2..64.
REQ-002 SHALL have parameter IN_W, default 16: width of each input lane.
REQ-003 SHALL have parameter ACC_EXT, default 8: accumulator guard bits above the tree sum width.
REQ-004 SHALL have parameter OUT_W, default 24: output width, IN_W <= OUT_W <= ACC_W.
REQ-005 SHALL have parameter SAT, default 1: 1 = saturate output, 0 = wrap (truncate).
REQ-006 SHALL have derived constants LVL = log2(NUM_IN), TREE_W = IN_W+LVL, ACC_W = TREE_W+ACC_EXT.
REQ-007 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-008 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have port vld_i, input, 1 bit: input beat valid.
REQ-010 SHALL have port first_i, input, 1 bit: beat starts a new accumulation, qualified by vld_i.
REQ-011 SHALL have port last_i, input, 1 bit: beat ends the accumulation, qualified by vld_i.
REQ-012 SHALL have port clr_i, input, 1 bit: synchronous flush.
REQ-013 SHALL have port data_i, input, NUM_IN*IN_W bits: flattened signed lanes, lane k at bits [k*IN_W +: IN_W].
REQ-014 SHALL have port acc_o, output, OUT_W bits: signed accumulated result.
REQ-015 SHALL have port vld_o, output, 1 bit: one-cycle pulse marking acc_o valid.
REQ-016 SHALL have port ovf_o, output, 1 bit: saturation occurred on this result; qualified by vld_o.

Function
REQ-017 SHALL reduce the lanes through LVL registered pairwise adder levels; level k operands sign-extended to IN_W+k bits, no truncation inside the tree.
REQ-018 SHALL carry vld_i, first_i and last_i through an LVL-deep side-band pipeline aligned with the tree levels.
REQ-019 SHALL, on a tree-output beat with first set, load acc = sign-extended tree sum; on a beat without first, set acc = acc + tree sum (ACC_W bits, wrap).
REQ-020 SHALL hold acc unchanged on bubble cycles (pipelined valid low); bubbles SHALL not break an accumulation.
REQ-021 SHALL, on a tree-output beat with last set, register acc_o = fmt(acc_next) and pulse vld_o high for exactly one cycle, LVL+1 cycles after the input beat was sampled (4 cycles for NUM_IN=8).
REQ-022 SHALL define fmt for SAT=1 as clamping to [-2^(OUT_W-1), 2^(OUT_W-1)-1] with ovf_o=1 when the clamp fires; for SAT=0, fmt SHALL be the low OUT_W bits and ovf_o SHALL be 0.
REQ-023 SHALL treat a beat with first and last both set as a single-beat result.
REQ-024 SHALL, for last without a preceding first, add onto the current acc (defined behaviour, not an error).
REQ-025 SHALL hold acc_o and ovf_o between results; vld_o SHALL be 0 otherwise.
REQ-026 SHALL sustain one input beat per cycle with no backpressure.
REQ-027 SHALL, when clr_i=1 at an edge, zero acc and all side-band valid bits, discarding in-flight beats, including any vld_i on that same edge (clr_i wins); tree data registers MAY keep their contents.
REQ-028 SHALL ignore first_i and last_i when vld_i=0.

Reset
REQ-029 SHALL, on rstn low, asynchronously clear all tree registers, side-band pipeline, acc, acc_o, ovf_o and vld_o to 0.
REQ-030 SHALL ensure an accumulation interrupted by reset produces no vld_o; the first result after release requires a fresh first_i.

Structure
REQ-031 SHALL take the log2 helper function and the lane-width and accumulator-width derivation from shared package adder_tree_pkg.
REQ-032 SHALL instantiate one reusable sub-module, adder_tree_level (parameters: pair count, operand width; registered signed pairwise add), once per level via generate.

Verification (NUM_IN=8, IN_W=16, ACC_EXT=8 unless noted)
REQ-033 SHALL test a single beat with all lanes=1 and first=last=1: acc_o=8, vld_o 4 cycles later, ovf_o=0.
REQ-034 SHALL test a single beat with all lanes=-32768 and OUT_W=24: acc_o=-262144, ovf_o=0.
REQ-035 SHALL test 3 beats (lanes=100, then -50, then 7) with one bubble between beats 2 and 3: one vld_o, acc_o=8*57=456.
REQ-036 SHALL test OUT_W=16, SAT=1 with all lanes=32767 single beat: acc_o=32767, ovf_o=1; with SAT=0: acc_o=low 16 bits of 262136 = -8 (0xFFF8), ovf_o=0.
REQ-037 SHALL test back-to-back single-beat results every cycle (lanes=k in cycle k): vld_o high continuously, acc_o=8k in order.
REQ-038 SHALL test rstn pulsed low, then separately clr_i pulsed, each mid 4-beat accumulation: no vld_o for that packet; a following first=last beat of lanes=2 gives acc_o=16.
